// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and FIFO-buffered load results
// onto one register-file write port, forcing the FIFO head ahead when it starves.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_lsu_valid,
    input  logic [4:0]  i_lsu_rd,
    input  logic [31:0] i_lsu_data,
    output logic        o_lsu_ready,
    output logic        o_write_en,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_age;

    logic        w_full;
    logic        w_empty;
    logic        w_starved;
    logic        w_push;
    logic        w_sel_fifo;
    logic        w_sel_alu;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_starved   = (r_age == AW'(STARVE_LIMIT));
    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Ready flags depend only on registered state so a pop never opens a push slot.
    assign o_lsu_ready = !w_full;
    assign o_alu_ready = !(w_full || w_starved);

    assign w_push     = i_lsu_valid && o_lsu_ready;
    assign w_sel_fifo = !w_empty && (!o_alu_ready || !i_alu_valid);
    assign w_sel_alu  = !w_sel_fifo && i_alu_valid && o_alu_ready;

    assign o_busy = !w_empty || o_write_en;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= i_lsu_rd;
            r_mem_data[r_wr_ptr] <= i_lsu_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_sel_fifo)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_sel_fifo)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_sel_fifo)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_age <= '0;
        else if (w_empty || w_sel_fifo)
            r_age <= '0;
        else if (!w_starved)
            r_age <= r_age + AW'(1);
    end

    // Writes to x0 still consume the slot but never assert the write strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_write_en <= 1'b0;
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
        end else begin
            o_write_en <= (w_sel_fifo && (w_head_rd != 5'd0)) ||
                          (w_sel_alu && (i_alu_rd != 5'd0));
            if (w_sel_fifo) begin
                o_rd_addr <= w_head_rd;
                o_rd_data <= w_head_data;
            end else if (w_sel_alu) begin
                o_rd_addr <= i_alu_rd;
                o_rd_data <= i_alu_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU path, LSU ordering, starvation forcing,
// full-FIFO back-pressure, x0 suppression and mid-operation reset.
module tb_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_rd = '0;
    logic [31:0] i_alu_data = '0;
    logic        o_alu_ready;
    logic        i_lsu_valid = 1'b0;
    logic [4:0]  i_lsu_rd = '0;
    logic [31:0] i_lsu_data = '0;
    logic        o_lsu_ready;
    logic        o_write_en;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_alu_valid (i_alu_valid),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .o_alu_ready (o_alu_ready),
        .i_lsu_valid (i_lsu_valid),
        .i_lsu_rd    (i_lsu_rd),
        .i_lsu_data  (i_lsu_data),
        .o_lsu_ready (o_lsu_ready),
        .o_write_en  (o_write_en),
        .o_rd_addr   (o_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int n;
        int ok_order;
        // Reset state
        #1;
        chk("rst_we", o_write_en, 0);
        chk("rst_addr", o_rd_addr, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_lsu_rdy", o_lsu_ready, 1);
        chk("rst_alu_rdy", o_alu_ready, 1);
        tick(); tick();
        i_rst = 1'b0;
        tick();
        chk("post_rst_we", o_write_en, 0);

        // ALU single write
        i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
        chk("alu_rdy", o_alu_ready, 1);
        tick();
        chk("alu_we", o_write_en, 1);
        chk("alu_addr", o_rd_addr, 5);
        chk("alu_data", o_rd_data, 32'hDEADBEEF);
        i_alu_valid = 0;
        tick();
        chk("idle_we", o_write_en, 0);
        chk("idle_addr_hold", o_rd_addr, 5);
        chk("idle_data_hold", o_rd_data, 32'hDEADBEEF);

        // ALU write to x0 is suppressed
        i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 32'h1234;
        chk("x0_rdy", o_alu_ready, 1);
        tick();
        chk("x0_we", o_write_en, 0);
        chk("x0_busy", o_busy, 0);
        i_alu_valid = 0;

        // LSU back-to-back, ALU idle: in-order, one per cycle
        for (int i = 0; i < 4; i++) begin
            i_lsu_valid = 1; i_lsu_rd = 5'(i + 1); i_lsu_data = 32'(8'h11 * (i + 1));
            chk("lsu_rdy", o_lsu_ready, 1);
            tick();
            if (i == 0) begin
                chk("lsu_lat_we", o_write_en, 0);
                chk("lsu_busy", o_busy, 1);
            end else begin
                chk("lsu_seq_we", o_write_en, 1);
                chk("lsu_seq_addr", o_rd_addr, 32'(i));
                chk("lsu_seq_data", o_rd_data, 32'(8'h11 * i));
            end
        end
        i_lsu_valid = 0;
        tick();
        chk("lsu_last_we", o_write_en, 1);
        chk("lsu_last_addr", o_rd_addr, 4);
        chk("lsu_last_data", o_rd_data, 32'h44);
        tick();
        chk("lsu_done_we", o_write_en, 0);
        chk("lsu_done_busy", o_busy, 0);

        // Starvation: ALU always valid, one load waits until age reaches 4
        i_alu_valid = 1; i_alu_rd = 5'd9; i_alu_data = 32'h99;
        i_lsu_valid = 1; i_lsu_rd = 5'd7; i_lsu_data = 32'h77;
        tick();
        i_lsu_valid = 0;
        chk("stv_first_alu", o_rd_addr, 9);
        for (int i = 1; i <= 4; i++) begin
            chk("stv_alu_rdy_hi", o_alu_ready, 1);
            tick();
            chk("stv_alu_addr", o_rd_addr, 9);
        end
        chk("stv_alu_rdy_lo", o_alu_ready, 0);
        tick();
        chk("stv_lsu_we", o_write_en, 1);
        chk("stv_lsu_addr", o_rd_addr, 7);
        chk("stv_lsu_data", o_rd_data, 32'h77);
        chk("stv_alu_rdy_back", o_alu_ready, 1);
        tick();
        chk("stv_after_addr", o_rd_addr, 9);
        chk("stv_after_busy", o_busy, 1);

        // Fill FIFO while ALU is continuously valid
        i_alu_rd = 5'd10; i_alu_data = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            i_lsu_valid = 1; i_lsu_rd = 5'(11 + i); i_lsu_data = 32'hB1 + 32'(i);
            chk("fill_lsu_rdy", o_lsu_ready, 1);
            tick();
        end
        i_lsu_valid = 0;
        chk("full_lsu_rdy", o_lsu_ready, 0);
        chk("full_alu_rdy", o_alu_ready, 0);
        n = 0;
        ok_order = 1;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (o_write_en && o_rd_addr != 5'd10) begin
                if (o_rd_addr != 5'(11 + n) || o_rd_data != 32'hB1 + 32'(n))
                    ok_order = 0;
                n++;
            end
        end
        chk("drain_count", n, 4);
        chk("drain_order", ok_order, 1);
        i_alu_valid = 0;
        tick();
        tick();
        chk("drain_idle_we", o_write_en, 0);
        chk("drain_idle_busy", o_busy, 0);

        // Reset mid-operation with three buffered loads
        i_alu_valid = 1; i_alu_rd = 5'd10; i_alu_data = 32'hA0;
        for (int i = 0; i < 3; i++) begin
            i_lsu_valid = 1; i_lsu_rd = 5'(20 + i); i_lsu_data = 32'hC0 + 32'(i);
            tick();
        end
        i_lsu_valid = 0;
        i_alu_valid = 0;
        chk("pre_rst_busy", o_busy, 1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_we", o_write_en, 0);
        chk("mid_rst_addr", o_rd_addr, 0);
        chk("mid_rst_data", o_rd_data, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_lsu_rdy", o_lsu_ready, 1);
        chk("mid_rst_alu_rdy", o_alu_ready, 1);
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_no_write", o_write_en, 0);
        end
        chk("post_rst_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
